simple_counter: RTL and testbench



---
 rtl/simple_counter.sv | 88 ++++++++
 tb/tb_simple_counter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/simple_counter.sv
// simple_counter: free-running up-counter with asynchronous active-low reset.
// Counts by STEP per clock up to MAX_COUNT, then wraps modulo MAX_COUNT+1
// (SATURATE=0) or holds at MAX_COUNT (SATURATE=1).
// Optional macro SIMPLE_COUNTER_TC_EN adds a registered terminal-count flag tc.
module simple_counter #(
  parameter int unsigned     WIDTH     = 7,
  parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned STEP      = 1,
  parameter bit              SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SIMPLE_COUNTER_TC_EN
  output logic [0:WIDTH-1] out,
  output logic             tc
`else
  output logic [0:WIDTH-1] out
`endif
);

  // Reject out-of-range configurations at elaboration.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("simple_counter: WIDTH=%0d outside 2..32", WIDTH);
  end
  if (MAX_COUNT < 1 || MAX_COUNT > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $error("simple_counter: MAX_COUNT=%0d outside 1..2**WIDTH-1", MAX_COUNT);
  end
  if (STEP < 1 || STEP > MAX_COUNT) begin : g_bad_step
    $error("simple_counter: STEP=%0d outside 1..MAX_COUNT", STEP);
  end

  // Arithmetic is done one bit wider so out+STEP cannot overflow silently.
  localparam logic [WIDTH:0]   MAX_W  = (WIDTH+1)'(MAX_COUNT);
  localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   WRAP_W = MAX_W + 1'b1;
  localparam logic [WIDTH-1:0] MAX_N  = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH:0]   nxt;
  logic [WIDTH:0]   wrapped;

  // Next count: add STEP, then wrap modulo MAX_COUNT+1 or saturate.
  always_comb begin
    nxt     = {1'b0, count_q} + STEP_W;
    wrapped = nxt - WRAP_W;
    count_d = nxt[WIDTH-1:0];
    if (nxt > MAX_W) begin
      if (SATURATE) begin
        count_d = MAX_N;
      end else begin
        count_d = wrapped[WIDTH-1:0];
      end
    end
  end

  // Count register, cleared asynchronously while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q is [WIDTH-1:0]; out is [0:WIDTH-1]; MSB maps to out[0].
  assign out = count_q;

`ifdef SIMPLE_COUNTER_TC_EN
  logic tc_q, tc_d;

  // Terminal flag is registered alongside the count so it aligns with out.
  always_comb begin
    tc_d = (count_d == MAX_N);
  end

  // Terminal-count register, cleared with the counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= tc_d;
    end
  end

  assign tc = tc_q;
`endif

endmodule

// File: tb/tb_simple_counter.sv
// Testbench for simple_counter: three instances (defaults, modulo-10 step-3,
// saturating at 20) share one clock and reset and are checked against a
// table of hand-computed values plus hand-written async reset sequences.
module tb_simple_counter;

  logic       clk;
  logic       rst;
  logic [0:6] out0;
  logic [0:3] out1;
  logic [0:4] out2;
`ifdef SIMPLE_COUNTER_TC_EN
  logic       tc0, tc1, tc2;
`endif

  int unsigned total;
  int unsigned bad;
  bit          running;

  simple_counter u_dut0 (
    .clk (clk),
    .rst (rst),
`ifdef SIMPLE_COUNTER_TC_EN
    .out (out0),
    .tc  (tc0)
`else
    .out (out0)
`endif
  );

  simple_counter #(.WIDTH(4), .MAX_COUNT(9), .STEP(3), .SATURATE(1'b0)) u_dut1 (
    .clk (clk),
    .rst (rst),
`ifdef SIMPLE_COUNTER_TC_EN
    .out (out1),
    .tc  (tc1)
`else
    .out (out1)
`endif
  );

  simple_counter #(.WIDTH(5), .MAX_COUNT(20), .STEP(1), .SATURATE(1'b1)) u_dut2 (
    .clk (clk),
    .rst (rst),
`ifdef SIMPLE_COUNTER_TC_EN
    .out (out2),
    .tc  (tc2)
`else
    .out (out2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int unsigned e0, input int unsigned e1,
                           input int unsigned e2);
    check({tag, " out0"}, out0, e0);
    check({tag, " out1"}, out1, e1);
    check({tag, " out2"}, out2, e2);
`ifdef SIMPLE_COUNTER_TC_EN
    check({tag, " tc0"}, tc0, (e0 == 127) ? 1 : 0);
    check({tag, " tc1"}, tc1, (e1 == 9) ? 1 : 0);
    check({tag, " tc2"}, tc2, (e2 == 20) ? 1 : 0);
`endif
  endtask

  // Bound checks on the small-range instances at every falling edge.
  always @(negedge clk) begin
    if (running) begin
      total++;
      if (out1 > 9 || out2 > 20) begin
        bad++;
        $display("FAIL bound: out1=%0d (max 9) out2=%0d (max 20)", out1, out2);
      end
    end
  end

  typedef struct {
    logic        rst;
    int unsigned cycles;
    int unsigned e0;
    int unsigned e1;
    int unsigned e2;
  } vec_t;

  vec_t vecs[17];

  initial begin
    total   = 0;
    bad     = 0;
    running = 1'b0;
    rst     = 1'b0;

    vecs = '{
      '{1'b0,  3,   0, 0,  0},
      '{1'b1,  1,   1, 3,  1},
      '{1'b1,  1,   2, 6,  2},
      '{1'b1,  1,   3, 9,  3},
      '{1'b1,  1,   4, 2,  4},
      '{1'b1,  1,   5, 5,  5},
      '{1'b1,  1,   6, 8,  6},
      '{1'b1,  1,   7, 1,  7},
      '{1'b1,  3,  10, 0, 10},
      '{1'b1, 10,  20, 0, 20},
      '{1'b1,  5,  25, 5, 20},
      '{1'b1,  5,  30, 0, 20},
      '{1'b1, 96, 126, 8, 20},
      '{1'b1,  1, 127, 1, 20},
      '{1'b1,  1,   0, 4, 20},
      '{1'b1,  1,   1, 7, 20},
      '{1'b1,  1,   2, 0, 20}
    };

    // Reset state before any clock edge.
    #1;
    check_all("reset_t0", 0, 0, 0);
    running = 1'b1;

    for (int i = 0; i < 17; i++) begin
      rst = vecs[i].rst;
      repeat (vecs[i].cycles) @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].e2);
    end

    // Advance default counter from 2 to 50.
    repeat (48) @(posedge clk);
    #1;
    check_all("pre_async", 50, 4, 20);

    // Assert reset between edges: outputs clear with no clock edge.
    #2;
    rst = 1'b0;
    #1;
    check_all("async_clr", 0, 0, 0);

    // Release off-edge; counting restarts at STEP.
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all("restart1", 1, 3, 1);
    @(posedge clk);
    #1;
    check_all("restart2", 2, 6, 2);
    @(posedge clk);
    #1;
    check_all("restart3", 3, 9, 3);

    running = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    bad++;
    $display("FAIL timeout: got no finish expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
